// File: rtl/id_dco.sv
// rtl/id_dco.sv - increment/decrement DCO: divide-by-DIV square wave with queued +/-1 clk period corrections
module id_dco #(
  parameter int DIV    = 8,
  parameter int DIV_W  = 4,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              inc,
  input  logic              dec,
  output logic              id_out,
  output logic              id_tick,
  output logic [PEND_W-1:0] pend,
  output logic              sat_err
);

  localparam int SUM_W = PEND_W + 2;
  localparam logic [DIV_W-1:0] L_DIV  = DIV_W'(DIV);
  localparam logic [DIV_W-1:0] L_HALF = DIV_W'(DIV / 2);
  localparam logic signed [SUM_W-1:0] L_PMAX = SUM_W'((2 ** (PEND_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] L_PMIN = SUM_W'(-(2 ** (PEND_W - 1)));

  logic [DIV_W-1:0]  r_cnt;
  logic [PEND_W-1:0] r_pend;
  logic              r_corr_done;
  logic              r_inc_q;
  logic              r_dec_q;
  logic              r_id_out;
  logic              r_id_tick;
  logic              r_sat_err;

  logic                    w_req_inc;
  logic                    w_req_dec;
  logic                    w_pend_pos;
  logic                    w_pend_neg;
  logic                    w_apply_inc;
  logic                    w_apply_dec;
  logic [1:0]              w_step;
  logic [DIV_W-1:0]        w_sum;
  logic                    w_wrap;
  logic [DIV_W-1:0]        w_cnt_next;
  logic signed [SUM_W-1:0] w_psum;
  logic [PEND_W-1:0]       w_pend_next;
  logic                    w_clamp;

  assign w_req_inc  = inc & ~r_inc_q;
  assign w_req_dec  = dec & ~r_dec_q;
  assign w_pend_neg = r_pend[PEND_W-1];
  assign w_pend_pos = ~r_pend[PEND_W-1] & (|r_pend);

  // Corrections are decided from registered state only, so a new request
  // can never influence the phase in the same cycle it is sampled.
  assign w_apply_inc = en & ~r_corr_done & w_pend_pos;
  assign w_apply_dec = en & ~r_corr_done & w_pend_neg;

  always_comb begin
    w_step = 2'd0;
    if (w_apply_inc) begin
      w_step = 2'd2;
    end else if (w_apply_dec) begin
      w_step = 2'd0;
    end else if (en) begin
      w_step = 2'd1;
    end
  end

  assign w_sum      = r_cnt + DIV_W'(w_step);
  assign w_wrap     = (w_sum >= L_DIV);
  assign w_cnt_next = w_wrap ? (w_sum - L_DIV) : w_sum;

  // Applying a correction always moves pend toward zero, so only a request
  // edge can push the sum past a rail; clamping therefore drops a request.
  always_comb begin
    w_psum = $signed({{2{r_pend[PEND_W-1]}}, r_pend})
           + $signed(SUM_W'(w_req_inc)) - $signed(SUM_W'(w_req_dec))
           - $signed(SUM_W'(w_apply_inc)) + $signed(SUM_W'(w_apply_dec));
    w_pend_next = w_psum[PEND_W-1:0];
    w_clamp     = 1'b0;
    if (w_psum > L_PMAX) begin
      w_pend_next = L_PMAX[PEND_W-1:0];
      w_clamp     = 1'b1;
    end else if (w_psum < L_PMIN) begin
      w_pend_next = L_PMIN[PEND_W-1:0];
      w_clamp     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_pend      <= '0;
      r_corr_done <= 1'b0;
      r_inc_q     <= 1'b0;
      r_dec_q     <= 1'b0;
      r_id_out    <= 1'b0;
      r_id_tick   <= 1'b0;
      r_sat_err   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_pend      <= w_pend_next;
      r_corr_done <= w_wrap ? 1'b0 : (r_corr_done | w_apply_inc | w_apply_dec);
      r_inc_q     <= inc;
      r_dec_q     <= dec;
      r_id_out    <= (w_cnt_next >= L_HALF);
      r_id_tick   <= w_wrap;
      r_sat_err   <= w_clamp;
    end
  end

  assign id_out  = r_id_out;
  assign id_tick = r_id_tick;
  assign pend    = r_pend;
  assign sat_err = r_sat_err;

endmodule
